// File: rtl/inst_decode_pkg.sv
// ============================================================================
// inst_decode_pkg : RV32I opcodes, format codes and the queued decode record
// Rev 1.0
// ============================================================================
`default_nettype none

package inst_decode_pkg;

  // Records are sized for the widest supported build; narrower builds use the low bits.
  localparam int c_max_xlen = 64;
  localparam int c_max_pc_w = 64;

  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_imm    = 7'b0010011;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_system = 7'b1110011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_reg    = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef struct packed {
    logic [6:0]            opcode;
    logic [4:0]            rd;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [c_max_xlen-1:0] imm;
    fmt_e                  fmt;
    logic [c_max_pc_w-1:0] pc;
    logic                  illegal;
  } dec_rec_t;

endpackage

`default_nettype wire

// File: rtl/inst_decode_queue_if.sv
// ============================================================================
// inst_decode_queue_if : fetch-side push and execute-side pop bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface inst_decode_queue_if #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
);
  import inst_decode_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [PC_W-1:0] in_pc;
  logic            flush;

  logic            out_valid;
  logic            out_ready;
  logic [6:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [XLEN-1:0] out_imm;
  fmt_e            out_fmt;
  logic [PC_W-1:0] out_pc;
  logic            out_illegal;

  modport master (
    output in_valid, in_inst, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_fmt, out_pc, out_illegal
  );

  modport slave (
    input  in_valid, in_inst, in_pc, flush, out_ready,
    output in_ready, out_valid, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_fmt, out_pc, out_illegal
  );

endinterface

`default_nettype wire

// File: rtl/inst_imm_gen.sv
// ============================================================================
// inst_imm_gen : combinational RV32I immediate / format / legality decode
// Rev 1.0
// ============================================================================
`default_nettype none

module inst_imm_gen
  import inst_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);

  logic [31:0] w_imm32;

  // Every supported opcode ends in 2'b11, so the opcode match also covers inst[1:0].
  always_comb begin
    w_imm32 = '0;
    fmt     = FMT_R;
    illegal = 1'b0;
    case (inst[6:0])
      c_op_load, c_op_imm, c_op_jalr, c_op_system: begin
        w_imm32 = {{20{inst[31]}}, inst[31:20]};
        fmt     = FMT_I;
      end
      c_op_store: begin
        w_imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        fmt     = FMT_S;
      end
      c_op_branch: begin
        w_imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        fmt     = FMT_B;
      end
      c_op_lui, c_op_auipc: begin
        w_imm32 = {inst[31:12], 12'b0};
        fmt     = FMT_U;
      end
      c_op_jal: begin
        w_imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        fmt     = FMT_J;
      end
      c_op_reg: begin
        w_imm32 = '0;
        fmt     = FMT_R;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  assign imm = XLEN'($signed(w_imm32));

endmodule

`default_nettype wire

// File: rtl/inst_decode_queue.sv
// ============================================================================
// inst_decode_queue : decodes fetched RV32I words into a DEPTH-entry FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

module inst_decode_queue
  import inst_decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int PC_W  = 32,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  inst_decode_queue_if.slave bus
);

  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cnt_w = $clog2(DEPTH + 1);

  logic [XLEN-1:0]    w_imm;
  fmt_e               w_fmt;
  logic               w_illegal;
  dec_rec_t           w_rec;
  dec_rec_t           w_head;
  dec_rec_t           w_out;
  logic               w_push;
  logic               w_pop;
  logic               unused_rec_bits;

  dec_rec_t           r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wptr;
  logic [c_ptr_w-1:0] r_rptr;
  logic [c_cnt_w-1:0] r_count;
  logic               r_live;

  function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_ptr_w'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  inst_imm_gen #(
    .XLEN    (XLEN)
  ) u_imm_gen (
    .inst    (bus.in_inst),
    .imm     (w_imm),
    .fmt     (w_fmt),
    .illegal (w_illegal)
  );

  always_comb begin
    w_rec         = '0;
    w_rec.opcode  = bus.in_inst[6:0];
    w_rec.rd      = bus.in_inst[11:7];
    w_rec.rs1     = bus.in_inst[19:15];
    w_rec.rs2     = bus.in_inst[24:20];
    w_rec.funct3  = bus.in_inst[14:12];
    w_rec.funct7  = bus.in_inst[31:25];
    w_rec.imm     = c_max_xlen'($signed(w_imm));
    w_rec.fmt     = w_fmt;
    w_rec.pc      = c_max_pc_w'(bus.in_pc);
    w_rec.illegal = w_illegal;
  end

  // r_live holds IN_READY low until the first edge after reset release.
  assign bus.in_ready  = r_live && (r_count < c_cnt_w'(DEPTH));
  assign bus.out_valid = (r_count != '0);
  assign w_push        = bus.in_valid & bus.in_ready;
  assign w_pop         = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live  <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_live <= 1'b1;
      if (bus.flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_mem[r_wptr] <= w_rec;
          r_wptr        <= ptr_inc(r_wptr);
        end
        if (w_pop) begin
          r_rptr <= ptr_inc(r_rptr);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign w_head = r_mem[r_rptr];

  // Popped slots keep stale data, so the head is masked whenever the queue is empty.
  always_comb begin
    w_out = '0;
    if (bus.out_valid) begin
      w_out = w_head;
    end
  end

  assign bus.out_opcode  = w_out.opcode;
  assign bus.out_rd      = w_out.rd;
  assign bus.out_rs1     = w_out.rs1;
  assign bus.out_rs2     = w_out.rs2;
  assign bus.out_funct3  = w_out.funct3;
  assign bus.out_funct7  = w_out.funct7;
  assign bus.out_imm     = w_out.imm[XLEN-1:0];
  assign bus.out_fmt     = w_out.fmt;
  assign bus.out_pc      = w_out.pc[PC_W-1:0];
  assign bus.out_illegal = w_out.illegal;

  assign unused_rec_bits = ^{w_out.imm, w_out.pc};

endmodule

`default_nettype wire
